imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, immediate output width; legal values 32 and 64.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  in_instr is valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block accepts in_instr this cycle.
REQ-006 SHALL have port in_instr  input  32  raw RV instruction word.
REQ-007 SHALL have port out_valid  output  1  out_* hold a decoded result.
REQ-008 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL have port out_imm  output  XLEN  sign-extended immediate.
REQ-010 SHALL have port out_fmt  output  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-011 SHALL have port err_sticky  output  1  sticky illegal-opcode flag (see Configuration).

Function
REQ-012 SHALL decode opcode in_instr[6:0]: I = 0000011, 0010011, 0011011, 1100111, 1110011; S = 0100011; B = 1100011; U = 0110111, 0010111; J = 1101111; R = 0110011, 0111011; any other opcode = illegal.
REQ-013 SHALL form immediates as I {i[31:20]}, S {i[31:25],i[11:7]}, B {i[31],i[7],i[30:25],i[11:8],0}, U {i[31:12],12'b0}, J {i[31],i[19:12],i[20],i[30:21],0}.
REQ-014 SHALL sign-extend every immediate to XLEN by replicating in_instr[31]; there are no constant-fill bits.
REQ-015 SHALL drive out_imm = 0 for R and illegal formats.
REQ-016 SHALL accept a word on a cycle where in_valid and in_ready are both 1, and transfer a result on a cycle where out_valid and out_ready are both 1.
REQ-017 SHALL present an accepted word on out_* one cycle after acceptance when the buffer was empty (latency 1).
REQ-018 SHALL sustain one transfer per cycle while out_ready stays 1.
REQ-019 SHALL implement a 2-entry skid buffer (main register plus skid register) controlled by states EMPTY, BUSY and FULL.
REQ-020 EMPTY: out_valid=0, in_ready=1; accept -> BUSY.
REQ-021 BUSY: out_valid=1, in_ready=1; accept without drain -> FULL; drain without accept -> EMPTY; accept with drain -> BUSY with the main register reloaded.
REQ-022 FULL: out_valid=1, in_ready=0; drain -> BUSY with skid moved into main.
REQ-023 SHALL drive in_ready from state only, with no combinational path from out_ready.
REQ-024 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-025 SHALL keep results in acceptance order, never dropping or duplicating one.

Reset
REQ-026 On reset assertion SHALL immediately force state EMPTY, out_valid=0, out_imm=0, out_fmt=0 and err_sticky=0, discarding any buffered entries.
REQ-027 SHALL drive in_ready=0 while reset is asserted, and in_ready=1 on the first cycle after deassertion.

Configuration
REQ-028 With macro IMM_GEN_ILLEGAL_TRAP_EN defined, err_sticky SHALL set on the cycle an illegal-format result transfers on the output, hold until reset, and force in_ready=0 while set.
REQ-029 Without IMM_GEN_ILLEGAL_TRAP_EN, err_sticky SHALL be tied 0 and illegal words SHALL pass through with out_fmt=7 and no stall.

Verification
REQ-030 XLEN=64, in 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_fmt=1, out_imm=0xFFFFFFFFFFFFFFFF.
REQ-031 XLEN=32, in 0x80000EB7 (lui) -> out_fmt=4, out_imm=0x80000000; in 0xFE000EE3 (beq, offset -4) -> out_fmt=3, out_imm=0xFFFFFFFC.
REQ-032 Hold out_ready=0 and send 3 words back-to-back -> in_ready=0 after 2 accepts; raise out_ready -> all 3 results emerge in order, none lost.
REQ-033 Random valid/ready toggling, 10k words -> output sequence equals a reference decode, and out_* stay stable during stalls.
REQ-034 Assert reset while FULL -> out_valid=0 immediately; post-reset first accepted word is the first output.
REQ-035 Send opcode 0x7F: with IMM_GEN_ILLEGAL_TRAP_EN -> out_fmt=7, err_sticky=1, and in_ready stays 0 until reset; without it -> out_fmt=7 and the next word is accepted normally.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a 2-entry skid buffer (valid/ready on both sides).
// Optional: define IMM_GEN_ILLEGAL_TRAP_EN to latch a sticky error and stall input after an illegal word leaves.
module imm_gen_pipe #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            err_sticky
);

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    state_t             state;
    logic               ready_q;
    logic [XLEN-1:0]    main_imm;
    logic [2:0]         main_fmt;
    logic [XLEN-1:0]    skid_imm;
    logic [2:0]         skid_fmt;

    logic               accept;
    logic               drain;
    logic               err_next;
    logic [2:0]         dec_fmt;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    dec_imm;

    // Every immediate is first built as a signed 32-bit value, then widened by sign extension.
    always_comb begin
        dec_fmt = FMT_ILL;
        imm32   = '0;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
                dec_fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                imm32   = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011, 7'b0111011: begin
                dec_fmt = FMT_R;
            end
            default: begin
                dec_fmt = FMT_ILL;
            end
        endcase
    end

    assign dec_imm = XLEN'(imm32);

    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign in_ready = ready_q && !reset;
    assign out_imm  = main_imm;
    assign out_fmt  = main_fmt;

`ifdef IMM_GEN_ILLEGAL_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (drain && main_fmt == FMT_ILL) begin
            err_q <= 1'b1;
        end
    end

    assign err_next   = err_q || (drain && main_fmt == FMT_ILL);
    assign err_sticky = err_q;
`else
    assign err_next   = 1'b0;
    assign err_sticky = 1'b0;
`endif

    // in_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            ready_q   <= 1'b1;
            main_imm  <= '0;
            main_fmt  <= FMT_R;
            skid_imm  <= '0;
            skid_fmt  <= FMT_R;
        end else begin
            ready_q <= !err_next;
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_imm  <= dec_imm;
                        main_fmt  <= dec_fmt;
                        out_valid <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && !drain) begin
                        skid_imm <= dec_imm;
                        skid_fmt <= dec_fmt;
                        ready_q  <= 1'b0;
                        state    <= FULL;
                    end else if (!accept && drain) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (accept && drain) begin
                        main_imm <= dec_imm;
                        main_fmt <= dec_fmt;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_imm <= skid_imm;
                        main_fmt <= skid_fmt;
                        state    <= BUSY;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized, self-checking bench for imm_gen_pipe (XLEN=64 and XLEN=32 instances driven in lockstep).
// Honours IMM_GEN_ILLEGAL_TRAP_EN the same way as the design.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [63:0] imm;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        err_sticky;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic        err_sticky32;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t exp_q[$];
    logic err_model = 1'b0;
    logic rand_ready = 1'b0;

    imm_gen_pipe #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .err_sticky(err_sticky)
    );

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .err_sticky(err_sticky32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode using arithmetic on the sign-extended word rather than bit concatenation.
    function automatic exp_t refDecode(input logic [31:0] w);
        exp_t   r;
        longint s;
        s     = longint'(signed'(w));
        r.fmt = 3'd7;
        r.imm = '0;
        case (w[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin
                r.fmt = 3'd1;
                r.imm = s >>> 20;
            end
            7'h23: begin
                r.fmt = 3'd2;
                r.imm = (s >>> 25) * 32 + longint'(w[11:7]);
            end
            7'h63: begin
                r.fmt = 3'd3;
                r.imm = (s >>> 31) * 4096 + longint'(w[7]) * 2048
                      + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            end
            7'h37, 7'h17: begin
                r.fmt = 3'd4;
                r.imm = (s >>> 12) * 4096;
            end
            7'h6F: begin
                r.fmt = 3'd5;
                r.imm = (s >>> 31) * 1048576 + longint'(w[19:12]) * 4096
                      + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            end
            7'h33, 7'h3B: begin
                r.fmt = 3'd0;
            end
            default: begin
                r.fmt = 3'd7;
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] randInstr();
        logic [6:0]  ops [12] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23,
                                  7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
        logic [31:0] w;
        w      = $urandom;
        w[6:0] = ops[$urandom_range(0, 11)];
`ifndef IMM_GEN_ILLEGAL_TRAP_EN
        if ($urandom_range(0, 15) == 0) w[6:0] = 7'h7F;
`endif
        return w;
    endfunction

    // Scoreboard: occupancy, handshake and head-of-queue checks every cycle, away from the rising edge.
    always @(negedge clk) begin
        exp_t head;
        if (reset) begin
            exp_q.delete();
            err_model = 1'b0;
        end else begin
            checkOutput("in_ready", in_ready, (exp_q.size() < 2) && !err_model);
            checkOutput("out_valid", out_valid, exp_q.size() != 0);
            checkOutput("err_sticky", err_sticky, err_model);
            if (out_valid && exp_q.size() != 0) begin
                head = exp_q[0];
                checkOutput("out_fmt", out_fmt, head.fmt);
                checkOutput("out_imm", out_imm, head.imm);
                checkOutput("out_imm32", out_imm32, {32'b0, head.imm[31:0]});
                if (out_ready) begin
                    void'(exp_q.pop_front());
`ifdef IMM_GEN_ILLEGAL_TRAP_EN
                    if (head.fmt == 3'd7) err_model = 1'b1;
`endif
                end
            end
            if (in_valid && in_ready) exp_q.push_back(refDecode(in_instr));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Presents one word and returns #1 after the edge on which it was accepted; in_valid stays high.
    task automatic applyStimulus(input logic [31:0] w);
        int   budget;
        logic acc;
        budget   = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_instr = w;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end while (!acc && budget < 200);
        if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        checkOutput("drain_empty", exp_q.size(), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 64'd0);
        checkOutput("rst_out_valid", out_valid, 64'd0);
        checkOutput("rst_out_imm", out_imm, 64'd0);
        checkOutput("rst_out_fmt", out_fmt, 64'd0);
        checkOutput("rst_err", err_sticky, 64'd0);
        reset = 1'b0;

        $display("[TB] directed decode");
        out_ready = 1'b1;
        applyStimulus(32'hFFF00093);
        in_valid = 1'b0;
        checkOutput("addi_fmt", out_fmt, 64'd1);
        checkOutput("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(32'h80000EB7);
        checkOutput("lui_fmt", out_fmt32, 64'd4);
        checkOutput("lui_imm32", out_imm32, 64'h8000_0000);
        applyStimulus(32'hFE000EE3);
        in_valid = 1'b0;
        checkOutput("beq_fmt", out_fmt32, 64'd3);
        checkOutput("beq_imm32", out_imm32, 64'hFFFF_FFFC);
        waitDrain();

        $display("[TB] back-pressure fill");
        out_ready = 1'b0;
        applyStimulus(32'h00A00513);
        applyStimulus(32'h00B52023);
        checkOutput("full_in_ready", in_ready, 64'd0);
        in_instr = 32'h123450B7;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("full_hold_ready", in_ready, 64'd0);
        out_ready = 1'b1;
        applyStimulus(32'h123450B7);
        in_valid = 1'b0;
        waitDrain();

        $display("[TB] random traffic");
        rand_ready = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_instr = $urandom;
                @(posedge clk);
                #1;
            end
            applyStimulus(randInstr());
        end
        in_valid   = 1'b0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        waitDrain();

        $display("[TB] reset while full");
        out_ready = 1'b0;
        applyStimulus(32'h00100093);
        applyStimulus(32'h00200093);
        in_valid = 1'b0;
        checkOutput("pre_rst_ready", in_ready, 64'd0);
        reset = 1'b1;
        #1;
        checkOutput("async_out_valid", out_valid, 64'd0);
        checkOutput("async_out_imm", out_imm, 64'd0);
        checkOutput("async_in_ready", in_ready, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(32'h00500113);
        in_valid = 1'b0;
        checkOutput("post_rst_fmt", out_fmt, 64'd1);
        checkOutput("post_rst_imm", out_imm, 64'd5);
        waitDrain();

        $display("[TB] illegal opcode");
        applyStimulus(32'h0000007F);
        in_valid = 1'b0;
        checkOutput("ill_fmt", out_fmt, 64'd7);
        checkOutput("ill_imm", out_imm, 64'd0);
        @(posedge clk);
        #1;
`ifdef IMM_GEN_ILLEGAL_TRAP_EN
        checkOutput("trap_err", err_sticky, 64'd1);
        in_valid = 1'b1;
        in_instr = 32'h00100093;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("trap_in_ready", in_ready, 64'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("trap_cleared", err_sticky, 64'd0);
`else
        checkOutput("no_trap_err", err_sticky, 64'd0);
        applyStimulus(32'h00700193);
        in_valid = 1'b0;
        checkOutput("after_ill_fmt", out_fmt, 64'd1);
        checkOutput("after_ill_imm", out_imm, 64'd7);
        waitDrain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
